cr_kme_key_assembler: RTL and testbench
=======================================

// Module: cr_kme_key_assembler
// PURPOSE
//   Downstream consumer of the KME 64-bit input FIFO. Pops beats using a valid/ack handshake,
//   where ack is asserted in the same cycle as the beat is accepted. Each frame is one header
//   beat followed by a length-specified run of payload beats. The payload is assembled into a
//   single wide key word and presented to the key engine through a valid/ready handshake.
// PARAMETERS
//   MAX_BEATS  4  maximum payload beats per frame, 1..15; sets the key_data width
// PORTS
//   clk        input   1              core clock; all state changes on rising edge
//   rst_n      input   1              asynchronous, active-low reset
//   in_data    input   64             FIFO head beat (fifo_out)
//   in_valid   input   1              FIFO head valid (fifo_out_valid)
//   in_ack     output  1              beat consumed this cycle (drives fifo_out_ack)
//   key_data   output  64*MAX_BEATS   assembled key; payload beat i at [64*i+63:64*i]
//   key_len    output  4              payload beat count of the presented key
//   key_tag    output  8              tag taken from header bits [63:56]
//   key_valid  output  1              key presented; held until key_ready
//   key_ready  input   1              key engine accepts key
//   hdr_error  output  1              one-cycle pulse: illegal header length dropped
//   busy       output  1              high when state != HDR
// BEHAVIOUR
//   Reset values: state=HDR, cnt=0, key_data=0, key_len=0, key_tag=0, key_valid=0,
//     hdr_error=0. Reset is asynchronous and honoured mid-frame; the partial frame is discarded.
//   in_ack = in_valid & (state != HOLD). It is combinational, with no bubble.
//     A beat is accepted when in_valid & in_ack.
//   Header decode: len = in_data[3:0], tag = in_data[63:56]. Bits [55:4] are ignored.
//   State HDR:
//     - Legal header (1 <= len <= MAX_BEATS): capture key_len<=len and key_tag<=tag,
//       clear key_data to 0, set cnt<=0, go to PAYLD.
//     - Illegal header (len==0 or len>MAX_BEATS): the beat is consumed. Register
//       hdr_error<=1 for exactly one cycle. Stay in HDR. key_len and key_tag are unchanged.
//   State PAYLD:
//     - Each accepted beat is written to slot cnt, then cnt<=cnt+1.
//     - When a beat is accepted with cnt==key_len-1: set key_valid<=1, go to HOLD.
//     - Gaps in in_valid stall the frame indefinitely; no timeout.
//   State HOLD:
//     - in_ack=0, and key_data, key_len and key_tag are stable.
//     - When key_valid & key_ready: key_valid<=0, go to HDR. The next header can be
//       accepted in the following cycle.
//     - key_ready while key_valid=0 has no effect.
//   Latency: key_valid rises on the clock edge that accepts the last payload beat.
//     Minimum frame period is len+2 cycles (header, len payload beats, one HOLD cycle).
//   Unused slots (index >= key_len) read 0.
//   cnt width is 4 bits; it never exceeds key_len-1, so it cannot wrap.
//   hdr_error is a registered output and never asserts in PAYLD or HOLD.
//   A header whose in_data[63:0] is all-zero is illegal (len 0) and is dropped.
// TESTING
//   1. Reset mid-PAYLD (after 2 of 4 beats) -> all outputs 0; next frame assembles cleanly.
//   2. MAX_BEATS=4, header 0xA5..._0003, then beats 0x11, 0x22, 0x33 back-to-back
//      -> key_valid on 4th edge, key_len=3, key_tag=0xA5, slot0..2=0x11/0x22/0x33, slot3=0.
//   3. key_ready held low 10 cycles with next header waiting -> in_ack=0, key stable;
//      ready pulse -> HDR, header acked next cycle.
//   4. Header len=0, then len=5 (MAX_BEATS=4) -> two single-cycle hdr_error pulses,
//      both beats acked, key_valid stays 0.
//   5. Header len=4, in_valid toggling 1/0 -> only valid beats counted;
//      key_valid after 4th accepted beat, slots in order.
//   6. Random frames vs FIFO model with random key_ready backpressure
//      -> no lost or duplicated beats, no FIFO underflow, tags match.

Source files
------------

// File: rtl/cr_kme_key_assembler.sv
// Key assembler: pops header + payload beats from the KME input FIFO and
// presents the payload as one wide key word to the key engine.
module cr_kme_key_assembler #(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [63:0]             in_data,
    input  logic                    in_valid,
    output logic                    in_ack,
    output logic [64*MAX_BEATS-1:0] key_data,
    output logic [3:0]              key_len,
    output logic [7:0]              key_tag,
    output logic                    key_valid,
    input  logic                    key_ready,
    output logic                    hdr_error,
    output logic                    busy
);

    localparam int unsigned BEAT_W = 64;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        PAYLD = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hdr_len;
    logic             hdr_legal;
    logic             accept;

    // Header decode and handshake; the FIFO is never acked while a key is held.
    assign hdr_len   = in_data[3:0];
    assign hdr_legal = (hdr_len != '0) && (hdr_len <= CNT_W'(MAX_BEATS));
    assign in_ack    = in_valid & (state != HOLD);
    assign accept    = in_valid & in_ack;
    assign busy      = (state != HDR);

    // Frame FSM: header capture, payload slot fill, key hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HDR;
            cnt       <= '0;
            key_data  <= '0;
            key_len   <= '0;
            key_tag   <= '0;
            key_valid <= 1'b0;
            hdr_error <= 1'b0;
        end else begin
            hdr_error <= 1'b0;
            case (state)
                HDR: begin
                    if (accept) begin
                        if (hdr_legal) begin
                            key_len  <= hdr_len;
                            key_tag  <= in_data[63:56];
                            key_data <= '0;
                            cnt      <= '0;
                            state    <= PAYLD;
                        end else begin
                            hdr_error <= 1'b1;
                        end
                    end
                end
                PAYLD: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < MAX_BEATS; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                key_data[BEAT_W*i +: BEAT_W] <= in_data;
                            end
                        end
                        if (cnt == key_len - CNT_W'(1)) begin
                            key_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (key_valid && key_ready) begin
                        key_valid <= 1'b0;
                        state     <= HDR;
                    end
                end
                default: begin
                    state <= HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr_kme_key_assembler.sv
// Directed and randomized self-checking bench for cr_kme_key_assembler.
module tb_cr_kme_key_assembler;

    localparam int unsigned MB = 4;

    logic            clk;
    logic            rst_n;
    logic [63:0]     in_data;
    logic            in_valid;
    logic            in_ack;
    logic [64*MB-1:0] key_data;
    logic [3:0]      key_len;
    logic [7:0]      key_tag;
    logic            key_valid;
    logic            key_ready;
    logic            hdr_error;
    logic            busy;

    int checks;
    int errors;

    cr_kme_key_assembler #(.MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ack    (in_ack),
        .key_data  (key_data),
        .key_len   (key_len),
        .key_tag   (key_tag),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .hdr_error (hdr_error),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; key_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({key_valid, hdr_error, busy, in_ack} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000", {key_valid, hdr_error, busy, in_ack});
        end
        checks++;
        if ({key_len, key_tag} !== 12'h0 || key_data !== '0) begin
            errors++; $display("FAIL reset_key got len=%0d tag=%h data=%h want 0", key_len, key_tag, key_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Header len 3 tag A5, three back-to-back payload beats.
    task automatic test_basic();
        in_data = 64'hA500_0000_0000_0003; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ack !== 1'b1) begin errors++; $display("FAIL basic_hdr_ack got %b want 1", in_ack); end
        tick();
        checks++;
        if (busy !== 1'b1 || key_len !== 4'd3 || key_tag !== 8'hA5 || key_valid !== 1'b0) begin
            errors++; $display("FAIL basic_hdr got busy=%b len=%0d tag=%h kv=%b want 1/3/a5/0", busy, key_len, key_tag, key_valid);
        end
        in_data = 64'h11; tick();
        in_data = 64'h22; tick();
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", key_valid); end
        in_data = 64'h33; tick();
        in_valid = 1'b0;
        checks++;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", key_valid); end
        checks++;
        if (key_data !== {64'h0, 64'h33, 64'h22, 64'h11}) begin
            errors++; $display("FAIL basic_data got %h want %h", key_data, {64'h0, 64'h33, 64'h22, 64'h11});
        end
    endtask

    // Key held with next header waiting; no ack until ready pulse.
    task automatic test_hold();
        in_data = 64'h3C00_0000_0000_0001; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (in_ack !== 1'b0) begin errors++; $display("FAIL hold_ack cyc %0d got %b want 0", i, in_ack); end
            tick();
            checks++;
            if (key_valid !== 1'b1 || key_len !== 4'd3 || key_tag !== 8'hA5 ||
                key_data !== {64'h0, 64'h33, 64'h22, 64'h11}) begin
                errors++; $display("FAIL hold_stable cyc %0d got kv=%b len=%0d tag=%h data=%h", i, key_valid, key_len, key_tag, key_data);
            end
        end
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        #1;
        checks++;
        if (key_valid !== 1'b0 || busy !== 1'b0 || in_ack !== 1'b1) begin
            errors++; $display("FAIL hold_release got kv=%b busy=%b ack=%b want 0/0/1", key_valid, busy, in_ack);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || key_len !== 4'd1 || key_tag !== 8'h3C || key_data !== '0) begin
            errors++; $display("FAIL hold_next_hdr got busy=%b len=%0d tag=%h data=%h", busy, key_len, key_tag, key_data);
        end
        in_data = 64'hDEAD_BEEF_0000_0001; tick();
        in_valid = 1'b0;
        checks++;
        if (key_valid !== 1'b1 || key_data !== {192'h0, 64'hDEAD_BEEF_0000_0001}) begin
            errors++; $display("FAIL hold_len1 got kv=%b data=%h", key_valid, key_data);
        end
        key_ready = 1'b1; tick(); key_ready = 1'b0;
    endtask

    // Illegal headers len 0 and len 5 are dropped with an error pulse each.
    task automatic test_hdr_error();
        in_data = 64'h0; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ack !== 1'b1) begin errors++; $display("FAIL err0_ack got %b want 1", in_ack); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (hdr_error !== 1'b1 || busy !== 1'b0 || key_len !== 4'd1 || key_tag !== 8'h3C) begin
            errors++; $display("FAIL err0 got err=%b busy=%b len=%0d tag=%h want 1/0/1/3c", hdr_error, busy, key_len, key_tag);
        end
        tick();
        checks++;
        if (hdr_error !== 1'b0) begin errors++; $display("FAIL err_pulse1 got %b want 0", hdr_error); end
        in_data = 64'hFF00_0000_0000_0005; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ack !== 1'b1) begin errors++; $display("FAIL err5_ack got %b want 1", in_ack); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (hdr_error !== 1'b1 || busy !== 1'b0 || key_tag !== 8'h3C || key_len !== 4'd1) begin
            errors++; $display("FAIL err5 got err=%b busy=%b tag=%h len=%0d", hdr_error, busy, key_tag, key_len);
        end
        tick();
        checks++;
        if (hdr_error !== 1'b0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL err_pulse2 got err=%b kv=%b want 0/0", hdr_error, key_valid);
        end
    endtask

    // Len 4 with in_valid toggling; only valid beats fill slots.
    task automatic test_gaps();
        in_data = 64'h7E00_0000_0000_0004; in_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 64'h1000 + 64'(i);
            tick();
            in_valid = 1'b0;
            checks++;
            if (key_valid !== (i == 3)) begin errors++; $display("FAIL gap_valid beat %0d got %b", i, key_valid); end
            if (i < 3) begin
                tick();
                checks++;
                if (key_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL gap_stall beat %0d got kv=%b busy=%b want 0/1", i, key_valid, busy);
                end
            end
        end
        checks++;
        if (key_data !== {64'h1003, 64'h1002, 64'h1001, 64'h1000} || key_len !== 4'd4 || key_tag !== 8'h7E) begin
            errors++; $display("FAIL gap_data got len=%0d tag=%h data=%h", key_len, key_tag, key_data);
        end
        key_ready = 1'b1; tick(); key_ready = 1'b0;
    endtask

    // Asynchronous reset after 2 of 4 payload beats, then a clean frame.
    task automatic test_reset_midframe();
        in_data = 64'h5A00_0000_0000_0004; in_valid = 1'b1; tick();
        in_data = 64'hAAAA; tick();
        in_data = 64'hBBBB; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || key_len !== 4'd0 || key_tag !== 8'h0 || key_data !== '0 ||
            key_valid !== 1'b0 || hdr_error !== 1'b0) begin
            errors++; $display("FAIL rst_mid got busy=%b len=%0d tag=%h kv=%b data=%h", busy, key_len, key_tag, key_valid, key_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        in_data = 64'h9900_0000_0000_0002; in_valid = 1'b1; tick();
        in_data = 64'hAA; tick();
        in_data = 64'hBB; tick();
        in_valid = 1'b0;
        checks++;
        if (key_valid !== 1'b1 || key_len !== 4'd2 || key_tag !== 8'h99 ||
            key_data !== {128'h0, 64'hBB, 64'hAA}) begin
            errors++; $display("FAIL rst_next got kv=%b len=%0d tag=%h data=%h", key_valid, key_len, key_tag, key_data);
        end
        key_ready = 1'b1; tick(); key_ready = 1'b0;
    endtask

    // Random frames through a FIFO model with random backpressure.
    task automatic test_random();
        logic [63:0]      fifo[$];
        logic [64*MB-1:0] exp_key[$];
        logic [3:0]       exp_len[$];
        logic [7:0]       exp_tag[$];
        logic [64*MB-1:0] k;
        logic [63:0]      d;
        logic [7:0]       tag;
        int               len;
        int               exp_err;
        int               got_err;
        int               cyc;
        logic             acc;
        logic             hs;
        exp_err = 0; got_err = 0; cyc = 0;
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(0, 6);
            tag = 8'($urandom);
            fifo.push_back({tag, 32'($urandom), 20'($urandom), 4'(len)});
            if (len >= 1 && len <= MB) begin
                k = '0;
                for (int b = 0; b < len; b++) begin
                    d = {32'($urandom), 32'($urandom)};
                    fifo.push_back(d);
                    k[64*b +: 64] = d;
                end
                exp_key.push_back(k); exp_len.push_back(4'(len)); exp_tag.push_back(tag);
            end else begin
                exp_err++;
            end
        end
        while ((fifo.size() != 0 || exp_key.size() != 0) && cyc < 4000) begin
            cyc++;
            in_valid  = (fifo.size() != 0) && ($urandom_range(0, 3) != 0);
            in_data   = (fifo.size() != 0) ? fifo[0] : 64'h0;
            key_ready = ($urandom_range(0, 2) == 0);
            #1;
            acc = in_valid && in_ack;
            hs  = key_valid && key_ready;
            if (in_ack && !in_valid) begin
                checks++; errors++; $display("FAIL rnd_underflow cyc %0d ack without valid", cyc);
            end
            tick();
            if (acc) void'(fifo.pop_front());
            if (hdr_error) got_err++;
            if (hs) begin
                checks++;
                if (exp_key.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_key cyc %0d got tag=%h want none", cyc, key_tag);
                end else begin
                    if (key_data !== exp_key[0] || key_len !== exp_len[0] || key_tag !== exp_tag[0]) begin
                        errors++; $display("FAIL rnd_key cyc %0d got len=%0d tag=%h want len=%0d tag=%h", cyc, key_len, key_tag, exp_len[0], exp_tag[0]);
                    end
                    void'(exp_key.pop_front()); void'(exp_len.pop_front()); void'(exp_tag.pop_front());
                end
            end
        end
        in_valid = 1'b0; key_ready = 1'b0;
        tick();
        if (hdr_error) got_err++;
        checks++;
        if (fifo.size() != 0 || exp_key.size() != 0) begin
            errors++; $display("FAIL rnd_drain got fifo=%0d keys=%0d left want 0/0", fifo.size(), exp_key.size());
        end
        checks++;
        if (got_err != exp_err) begin
            errors++; $display("FAIL rnd_hdr_err got %0d want %0d", got_err, exp_err);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_basic();
        test_hold();
        test_hdr_error();
        test_gaps();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
